// File: rtl/ultra_medidor.sv
// ----------------------------------------------------------------------------
// ultra_medidor: HC-SR04 style ranger driver with echo-width measurement and
// thresholded, N-consecutive confirmed active-low presence output. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ultra_medidor #(
    parameter int W              = 22,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int UMBRAL_CYCLES  = 58_000,
    parameter int CONFIRM        = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         eco,
    output logic         trig,
    output logic         detecta_n,
    output logic [W-1:0] distancia,
    output logic         valido
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam logic [W-1:0]  PER_LAST  = W'(PERIOD_CYCLES - 1);
    localparam logic [W-1:0]  TRIG_LAST = W'(TRIG_CYCLES - 1);
    localparam logic [W-1:0]  TMO_LAST  = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0]  TMO       = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0]  UMBRAL    = W'(UMBRAL_CYCLES);
    localparam logic [CW-1:0] CONF      = CW'(CONFIRM);

    typedef enum logic [1:0] {
        ESPERA     = 2'd0,
        DISPARO    = 2'd1,
        ESPERA_ECO = 2'd2,
        MIDE       = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [W-1:0]  per_q;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  ancho_q, ancho_d;
    logic [W-1:0]  dist_q, dist_d;
    logic [CW-1:0] hits_q, hits_d;
    logic [CW-1:0] misses_q, misses_d;
    logic          trig_q, trig_d;
    logic          det_q, det_d;
    logic          valido_q, valido_d;
    logic          eco_m_q, eco_s_q, eco_p_q;
    logic          subida;
    logic          publica;
    logic [W-1:0]  ancho_pub;

    assign subida    = eco_s_q & ~eco_p_q;
    assign trig      = trig_q;
    assign detecta_n = det_q;
    assign distancia = dist_q;
    assign valido    = valido_q;

    always_comb begin
        estado_d  = estado_q;
        t_d       = t_q;
        ancho_d   = ancho_q;
        trig_d    = trig_q;
        publica   = 1'b0;
        ancho_pub = '0;
        case (estado_q)
            ESPERA: begin
                trig_d = 1'b0;
                if (per_q == PER_LAST) begin
                    estado_d = DISPARO;
                    trig_d   = 1'b1;
                    t_d      = '0;
                end
            end
            DISPARO: begin
                if (t_q == TRIG_LAST) begin
                    estado_d = ESPERA_ECO;
                    trig_d   = 1'b0;
                    t_d      = '0;
                end else begin
                    t_d = t_q + W'(1);
                end
            end
            ESPERA_ECO: begin
                t_d = t_q + W'(1);
                // Only a fresh rise starts a measurement; a line already high times out.
                if (subida) begin
                    estado_d = MIDE;
                    ancho_d  = W'(1);
                end else if (t_q == TMO_LAST) begin
                    publica   = 1'b1;
                    ancho_pub = TMO;
                    estado_d  = ESPERA;
                end
            end
            MIDE: begin
                if (!eco_s_q) begin
                    publica   = 1'b1;
                    ancho_pub = ancho_q;
                    estado_d  = ESPERA;
                end else if (ancho_q == TMO) begin
                    publica   = 1'b1;
                    ancho_pub = TMO;
                    estado_d  = ESPERA;
                end else begin
                    ancho_d = ancho_q + W'(1);
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        det_d    = det_q;
        dist_d   = dist_q;
        valido_d = publica;
        if (publica) begin
            dist_d = ancho_pub;
            if (ancho_pub < UMBRAL) begin
                hits_d   = (hits_q == CONF) ? CONF : hits_q + CW'(1);
                misses_d = '0;
                if (hits_d == CONF) det_d = 1'b0;
            end else begin
                misses_d = (misses_q == CONF) ? CONF : misses_q + CW'(1);
                hits_d   = '0;
                if (misses_d == CONF) det_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ESPERA;
            per_q    <= '0;
            t_q      <= '0;
            ancho_q  <= '0;
            dist_q   <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            trig_q   <= 1'b0;
            det_q    <= 1'b1;
            valido_q <= 1'b0;
            eco_m_q  <= 1'b0;
            eco_s_q  <= 1'b0;
            eco_p_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            per_q    <= (per_q == PER_LAST) ? '0 : per_q + W'(1);
            t_q      <= t_d;
            ancho_q  <= ancho_d;
            dist_q   <= dist_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            trig_q   <= trig_d;
            det_q    <= det_d;
            valido_q <= valido_d;
            eco_m_q  <= eco;
            eco_s_q  <= eco_m_q;
            eco_p_q  <= eco_s_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ultra_medidor.sv
// ----------------------------------------------------------------------------
// tb_ultra_medidor: directed table of echo widths plus hand-written timing,
// stuck-echo and mid-measurement reset sequences. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ultra_medidor;

    localparam int W    = 22;
    localparam int TRIG = 4;
    localparam int TMO  = 100;
    localparam int PER  = 300;
    localparam int UMB  = 40;
    localparam int CONF = 2;

    typedef struct {
        int           len;
        logic [W-1:0] d;
        logic         det;
        int           cyc;   // 0: latency not checked
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         eco = 1'b0;
    logic         trig;
    logic         detecta_n;
    logic [W-1:0] distancia;
    logic         valido;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ultra_medidor #(
        .W(W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
        .PERIOD_CYCLES(PER), .UMBRAL_CYCLES(UMB), .CONFIRM(CONF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .eco(eco), .trig(trig),
        .detecta_n(detecta_n), .distancia(distancia), .valido(valido)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (trig === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One measurement period: after trig falls, echo high from cycle 10 for len cycles.
    task automatic run_vec(input int len, input bit stuck, output int vcyc, output int nv,
                           output logic [W-1:0] d, output logic det);
        bit ok;
        vcyc = 0; nv = 0; d = '0; det = 1'bx;
        if (stuck) eco = 1'b1;
        wait_trig(1'b1, ok);
        if (!ok) chk("trig_rise_wait", 0, 1);
        wait_trig(1'b0, ok);
        if (!ok) chk("trig_fall_wait", 0, 1);
        for (int c = 1; c <= 250; c++) begin
            if (!stuck) eco = (c > 10) && (c <= 10 + len);
            @(negedge clk);
            if (valido) begin
                nv++;
                if (nv == 1) begin
                    vcyc = c;
                    d    = distancia;
                    det  = detecta_n;
                end
            end
        end
        eco = 1'b0;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input bit stuck);
        int vcyc, nv;
        logic [W-1:0] d;
        logic det;
        run_vec(v.len, stuck, vcyc, nv, d, det);
        chk({tag, "_valido_count"}, nv, 1);
        chk({tag, "_distancia"}, d, v.d);
        chk({tag, "_detecta_n"}, det, v.det);
        if (v.cyc != 0) chk({tag, "_latency"}, vcyc, v.cyc);
    endtask

    vec_t tbl[11];

    initial begin
        int n, hi, nval;
        bit ok;

        tbl[0]  = '{len: 0,   d: 100, det: 1'b1, cyc: 100};
        tbl[1]  = '{len: 25,  d: 25,  det: 1'b1, cyc: 38};
        tbl[2]  = '{len: 25,  d: 25,  det: 1'b0, cyc: 38};
        tbl[3]  = '{len: 60,  d: 60,  det: 1'b0, cyc: 73};
        tbl[4]  = '{len: 60,  d: 60,  det: 1'b1, cyc: 73};
        tbl[5]  = '{len: 40,  d: 40,  det: 1'b1, cyc: 53};
        tbl[6]  = '{len: 40,  d: 40,  det: 1'b1, cyc: 53};
        tbl[7]  = '{len: 39,  d: 39,  det: 1'b1, cyc: 52};
        tbl[8]  = '{len: 39,  d: 39,  det: 1'b0, cyc: 52};
        tbl[9]  = '{len: 150, d: 100, det: 1'b0, cyc: 0};
        tbl[10] = '{len: 150, d: 100, det: 1'b1, cyc: 0};

        repeat (3) @(negedge clk);
        chk("rst_trig", trig, 0);
        chk("rst_detecta_n", detecta_n, 1);
        chk("rst_distancia", distancia, 0);
        chk("rst_valido", valido, 0);

        rst_n = 1'b1;
        n = 0; nval = 0;
        while (!trig && n < 400) begin
            @(negedge clk);
            n++;
            if (valido) nval++;
        end
        chk("first_trig_delay", n, PER);
        chk("no_valido_before_trig", nval, 0);

        hi = 1; n = 0;
        while (trig && n < 400) begin
            @(negedge clk);
            n++;
            if (trig) hi++;
        end
        chk("trig_width", hi, TRIG);
        while (!trig && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("trig_period", n, PER);
        chk("idle_detecta_n", detecta_n, 1);

        for (int i = 0; i < 11; i++)
            check_vec($sformatf("tbl%0d", i), tbl[i], 1'b0);

        check_vec("stuck", '{len: 0, d: 100, det: 1'b1, cyc: 100}, 1'b1);
        check_vec("close_a", '{len: 25, d: 25, det: 1'b1, cyc: 38}, 1'b0);
        check_vec("close_b", '{len: 25, d: 25, det: 1'b0, cyc: 38}, 1'b0);

        // Abort in the middle of a measurement.
        wait_trig(1'b1, ok);
        if (!ok) chk("abort_rise_wait", 0, 1);
        wait_trig(1'b0, ok);
        if (!ok) chk("abort_fall_wait", 0, 1);
        nval = 0;
        for (int c = 1; c <= 30; c++) begin
            eco = (c > 10);
            @(negedge clk);
            if (valido) nval++;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_trig", trig, 0);
        chk("abort_detecta_n", detecta_n, 1);
        chk("abort_distancia", distancia, 0);
        chk("abort_valido", valido, 0);
        eco = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (valido) nval++;
        end
        rst_n = 1'b1;
        n = 0;
        while (!trig && n < 400) begin
            @(negedge clk);
            n++;
            if (valido) nval++;
        end
        chk("abort_no_valido", nval, 0);
        chk("abort_next_trig", n, PER);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
